// File: rtl/fp_accumulator.sv
// Single-precision accumulator (acc = acc + prod) with a four-state align/add/normalise FSM.
// Optional macro OVF_SAT_EN: exponent overflow saturates to max finite instead of infinity.
module fp_accumulator #(
    parameter int GRS_BITS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] prod,
    input  logic        clear,
    output logic [31:0] acc_out,
    output logic        out_valid
);

    localparam int W   = 24 + GRS_BITS;
    localparam int LZW = $clog2(W + 1);

`ifdef OVF_SAT_EN
    localparam logic [30:0] OVF_MAG = 31'h7F7F_FFFF;
`else
    localparam logic [30:0] OVF_MAG = 31'h7F80_0000;
`endif
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} state_t;

    state_t state, state_nx;

    logic [31:0]    op_a, op_b;
    logic           nan_q, sign_q, sub_q;
    logic [7:0]     exp_q;
    logic [W-1:0]   mant_a_q, mant_b_q;
    logic [W:0]     sum_q;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = ALIGN;
            end
            ALIGN:   state_nx = ADD;
            ADD:     state_nx = NORM;
            NORM:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Alignment: zero-exponent operands count as 0; the smaller magnitude is shifted right.
    logic [30:0]  mag_a, mag_b, mag_big, mag_small;
    logic         swap;
    logic [7:0]   shamt;
    logic [W-1:0] ext_big, ext_small, lost_mask, shifted;

    always_comb begin
        mag_a     = (op_a[30:23] == 8'd0) ? 31'd0 : op_a[30:0];
        mag_b     = (op_b[30:23] == 8'd0) ? 31'd0 : op_b[30:0];
        swap      = mag_b > mag_a;
        mag_big   = swap ? mag_b : mag_a;
        mag_small = swap ? mag_a : mag_b;
        shamt     = mag_big[30:23] - mag_small[30:23];
        ext_big   = (mag_big[30:23] == 8'd0) ? '0 : {1'b1, mag_big[22:0], {GRS_BITS{1'b0}}};
        ext_small = (mag_small[30:23] == 8'd0) ? '0 : {1'b1, mag_small[22:0], {GRS_BITS{1'b0}}};
        lost_mask = ~({W{1'b1}} << shamt);
        if (shamt >= 8'(W - 1)) begin
            shifted = {{(W-1){1'b0}}, |ext_small};
        end else begin
            shifted    = ext_small >> shamt;
            shifted[0] = shifted[0] | (|(ext_small & lost_mask));
        end
    end

    // Normalisation: a carry needs one right shift, otherwise shift left by the leading-zero count.
    logic [LZW-1:0]    lzc;
    logic [22:0]       frac;
    logic signed [9:0] exp_n;
    logic [31:0]       result;

    always_comb begin
        lzc = '0;
        for (int i = 0; i < W; i++) begin
            if (sum_q[i]) lzc = LZW'(W - 1 - i);
        end
        if (sum_q[W]) begin
            frac  = 23'(sum_q >> (GRS_BITS + 1));
            exp_n = $signed({2'b00, exp_q}) + 10'sd1;
        end else begin
            frac  = 23'((sum_q[W-1:0] << lzc) >> GRS_BITS);
            exp_n = $signed({2'b00, exp_q}) - $signed(10'(lzc));
        end
        if (nan_q)                   result = QNAN;
        else if (sum_q == '0)        result = 32'h0;
        else if (exp_n <= 10'sd0)    result = 32'h0;
        else if (exp_n >= 10'sd255)  result = {sign_q, OVF_MAG};
        else                         result = {sign_q, exp_n[7:0], frac};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_a      <= '0;
            op_b      <= '0;
            nan_q     <= 1'b0;
            sign_q    <= 1'b0;
            sub_q     <= 1'b0;
            exp_q     <= '0;
            mant_a_q  <= '0;
            mant_b_q  <= '0;
            sum_q     <= '0;
            acc_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state == NORM);
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a <= clear ? 32'h0 : acc_out;
                        op_b <= prod;
                    end
                end
                ALIGN: begin
                    nan_q    <= (op_a[30:23] == 8'hFF) || (op_b[30:23] == 8'hFF);
                    sign_q   <= swap ? op_b[31] : op_a[31];
                    sub_q    <= op_a[31] ^ op_b[31];
                    exp_q    <= mag_big[30:23];
                    mant_a_q <= ext_big;
                    mant_b_q <= shifted;
                end
                ADD: begin
                    sum_q <= sub_q ? ({1'b0, mant_a_q} - {1'b0, mant_b_q})
                                   : ({1'b0, mant_a_q} + {1'b0, mant_b_q});
                end
                NORM:    acc_out <= result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_accumulator.sv
// Scoreboard bench for fp_accumulator: exact wide-integer reference model, directed cases, random traffic.
module tb_fp_accumulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] prod;
    logic        clear;
    logic [31:0] acc_out;
    logic        out_valid;

    fp_accumulator dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod      (prod),
        .clear     (clear),
        .acc_out   (acc_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [31:0] acc;
        int          accept_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_acc = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Exact sum of the two operands as wide integers, then truncated toward zero.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [299:0] ma, mb, mag, tmp;
        logic         s;
        int           p, e;
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FC0_0000;
        ma = '0;
        mb = '0;
        if (a[30:23] != 8'd0) ma = 300'({1'b1, a[22:0]}) << (int'(a[30:23]) - 1);
        if (b[30:23] != 8'd0) mb = 300'({1'b1, b[22:0]}) << (int'(b[30:23]) - 1);
        if (a[31] == b[31])  begin mag = ma + mb; s = a[31]; end
        else if (ma >= mb)   begin mag = ma - mb; s = a[31]; end
        else                 begin mag = mb - ma; s = b[31]; end
        if (mag == '0) return 32'h0;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e = p - 22;
        if (e <= 0) return 32'h0;
`ifdef OVF_SAT_EN
        if (e >= 255) return {s, 31'h7F7F_FFFF};
`else
        if (e >= 255) return {s, 31'h7F80_0000};
`endif
        tmp = mag >> (p - 23);
        return {s, e[7:0], tmp[22:0]};
    endfunction

    // Monitor: every out_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got acc_out %h, expected no output", acc_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("acc_out", acc_out, e.acc);
                check("latency", 32'(cycle - e.accept_cyc), 32'd3);
            end
        end
    end

    // Issue one product; returns the cycle index of the accepting edge. in_valid stays high afterwards.
    task automatic send(input logic [31:0] p, input logic c, input bit use_exp,
                        input logic [31:0] exp_val, output int acc_cyc);
        bit   done = 0;
        exp_t e;
        acc_cyc = -1;
        @(negedge clk);
        in_valid = 1'b1;
        prod     = p;
        clear    = c;
        for (int n = 0; n < 20 && !done; n++) begin
            if (in_ready) begin
                done      = 1;
                acc_cyc   = cycle + 1;
                model_acc = use_exp ? exp_val : ref_add(c ? 32'h0 : model_acc, p);
                e.acc        = model_acc;
                e.accept_cyc = acc_cyc;
                sb.push_back(e);
                @(posedge clk);
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 for 20 cycles, expected 1");
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            clear    = 1'($urandom);
            prod     = $urandom;
        end
    endtask

    task automatic drain();
        idle(1);
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        #1;
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [31:0] rand_fp();
        int r;
        r = $urandom_range(0, 99);
        if (r < 2)  return 32'h7FC0_0000;
        if (r < 5)  return {1'($urandom), 8'd0, 23'($urandom)};
        if (r < 7)  return {1'($urandom), 31'd0};
        if (r < 11) return {1'($urandom), 8'($urandom_range(250, 254)), 23'($urandom)};
        if (r < 22) return {~model_acc[31], model_acc[30:0] ^ 31'($urandom_range(0, 255))};
        return {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
    endfunction

    int t1, t2;

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        clear    = 1'b0;
        prod     = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_acc_out", acc_out, 32'h0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b1;

        // 1.0 then 1.0 with in_valid held throughout: one transfer per four clocks.
        send(32'h3F80_0000, 1'b1, 1, 32'h3F80_0000, t1);
        send(32'h3F80_0000, 1'b0, 1, 32'h4000_0000, t2);
        check("throughput", 32'(t2 - t1), 32'd4);
        drain();

        // Truncation toward zero: 21.16 - 2.76.
        send(32'h41A9_47AE, 1'b1, 1, 32'h41A9_47AE, t1);
        send(32'hC030_A3D7, 1'b0, 1, 32'h4193_3333, t1);
        drain();

        // Exact cancellation gives +0.
        send(32'h4093_3333, 1'b1, 1, 32'h4093_3333, t1);
        send(32'hC093_3333, 1'b0, 1, 32'h0000_0000, t1);
        drain();

        // Exponent overflow.
        send(32'h7F7F_FFFF, 1'b1, 1, 32'h7F7F_FFFF, t1);
`ifdef OVF_SAT_EN
        send(32'h7F7F_FFFF, 1'b0, 1, 32'h7F7F_FFFF, t1);
`else
        send(32'h7F7F_FFFF, 1'b0, 1, 32'h7F80_0000, t1);
`endif
        drain();

        // qNaN is sticky until a clearing add; idle clears in between must do nothing.
        send(32'h7FC0_0000, 1'b0, 1, 32'h7FC0_0000, t1);
        idle(3);
        send(32'h3F80_0000, 1'b0, 1, 32'h7FC0_0000, t1);
        idle(2);
        send(32'h3F80_0000, 1'b1, 1, 32'h3F80_0000, t1);
        drain();

        // Reset during NORM aborts the add: no out_valid and acc_out back to 0.
        send(32'h4000_0000, 1'b0, 1, 32'h4040_0000, t1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        void'(sb.pop_back());
        model_acc = 32'h0;
        #1;
        check("abort_acc_out", acc_out, 32'h0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("abort_out_valid_held", 32'(out_valid), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_no_pulse", 32'(out_valid), 32'd0);

        // Random traffic against the reference model.
        for (int k = 0; k < 300; k++) begin
            send(rand_fp(), ($urandom_range(0, 9) == 0), 0, 32'h0, t1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
